// File: rtl/divider_pkg.sv
// Shared definitions for the 32-bit sequential divider.
//   DIV_WIDTH     - operand width
//   DIV_STEPS     - restoring iterations per operation
//   DIV_ZERO_QUOT - quotient returned for a zero divisor
//   div_state_t   - controller states
//   mag()         - magnitude of an operand, two's-complement when signed
package divider_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] v,
                                                 input logic is_signed);
        return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
//   rem_in  - current partial remainder (always < divisor)
//   dvd_bit - next dividend bit, MSB first
//   divisor - divisor magnitude
//   rem_out - new partial remainder
//   q_bit   - quotient bit produced by this step
module div_step
    import divider_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic                 dvd_bit,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic                 q_bit
);
    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the subtraction succeeds the result is below the divisor, so
        // the 32-bit wrapped difference is exact.
        diff    = shifted[DIV_WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[DIV_WIDTH-1:0];
    end
endmodule

// File: rtl/divider.sv
// 32-bit sequential signed/unsigned divider, one restoring step per cycle.
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready - request handshake on x, y, div_signed
//   flush             - synchronous cancel, highest priority
//   out_valid/out_ready - result handshake on quotient, remainder
// Result appears 32 edges after accept; quotient truncates toward zero,
// remainder carries the dividend's sign. Divide by zero returns all-ones
// quotient and the original dividend as remainder.
module divider
    import divider_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIV_WIDTH-1:0] x,
    input  logic [DIV_WIDTH-1:0] y,
    input  logic                 div_signed,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);
    div_state_t           state, state_nxt;
    logic [5:0]           cnt;
    logic [DIV_WIDTH-1:0] dvd;      // dividend magnitude, becomes quotient
    logic [DIV_WIDTH-1:0] rem;      // partial remainder
    logic [DIV_WIDTH-1:0] dsr;      // divisor magnitude
    logic                 qsign, rsign, sgn, yzero;
    logic [DIV_WIDTH-1:0] step_rem;
    logic                 step_q;
    logic                 accept;

    assign accept = (state == IDLE) && in_valid && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = CALC;
                CALC:    if (cnt == 6'(DIV_STEPS - 1)) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    div_step u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[DIV_WIDTH-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            dvd   <= '0;
            rem   <= '0;
            dsr   <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            sgn   <= 1'b0;
            yzero <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            dvd   <= mag(x, div_signed);
            rem   <= '0;
            dsr   <= mag(y, div_signed);
            qsign <= x[DIV_WIDTH-1] ^ y[DIV_WIDTH-1];
            rsign <= x[DIV_WIDTH-1];
            sgn   <= div_signed;
            yzero <= (y == '0);
        end else if (state == CALC && !flush) begin
            cnt   <= cnt + 6'd1;
            rem   <= step_rem;
            dvd   <= {dvd[DIV_WIDTH-2:0], step_q};
        end
    end

    // With a zero divisor every step succeeds, leaving rem = |x|; the sign
    // fix-up then reproduces x exactly, so only the quotient needs overriding.
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (state == DONE) begin
            if (yzero)             quotient = DIV_ZERO_QUOT;
            else if (sgn && qsign) quotient = -dvd;
            else                   quotient = dvd;
            remainder = (sgn && rsign) ? -rem : rem;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed corner cases, handshake, flush and
// reset scenarios, then a random regression against an arithmetic model.
module tb_divider;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        div_signed = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] x = '0, y = '0;
    logic        in_ready, out_valid;
    logic [31:0] quotient, remainder;

    divider dut (
        .clock      (clock),
        .reset      (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .div_signed (div_signed),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    bit   have = 0;
    logic prev_ov = 1'b0;
    int   errors = 0, checks = 0;
    bit   rdy_rand = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa, sb_;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            q = 32'(sa / sb_);
            r = 32'(sa % sb_);
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clock) if (rdy_rand) out_ready = 1'($urandom_range(0, 1));

    // Monitor: pops on each new result, then checks data every valid cycle.
    always @(negedge clock) begin
        chk("ready_valid_exclusive", {31'b0, in_ready & out_valid}, 32'h0);
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got out_valid=1 expected none (t=%0t)", $time);
                have = 0;
            end else begin
                cur  = sb.pop_front();
                have = 1;
                chk("latency", 32'(cyc - cur.acc), 32'd32);
            end
        end
        if (out_valid && have) begin
            chk("quotient", quotient, cur.q);
            chk("remainder", remainder, cur.r);
        end
        if (!out_valid) have = 0;
        prev_ov = out_valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, input logic [31:0] eq, input logic [31:0] er);
        int   n = 0;
        exp_t e;
        @(negedge clock);
        while (!in_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            timeout("issue_wait_in_ready");
            return;
        end
        x = a; y = b; div_signed = s; in_valid = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        x = $urandom; y = $urandom; div_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || !in_ready) timeout("wait_idle");
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!out_valid) timeout("wait_out_valid");
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] a, b, eq, er;
        logic        s;

        vecs[0] = '{32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[1] = '{32'hFFFF_FFFF, 32'd1,        1'b0, 32'hFFFF_FFFF, 32'h0};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0};
        vecs[3] = '{32'h1234_5678, 32'h0,        1'b0, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[4] = '{32'h1234_5678, 32'h0,        1'b1, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[5] = '{32'hFFFF_FF00, 32'h0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h8000_0000};
        vecs[7] = '{32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2};

        // Reset state while reset is held.
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        #6 reset_n = 1'b1;

        // First request accepted on the first rising edge after release.
        issue(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2);
        wait_idle();

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, 1, vecs[i].q, vecs[i].r);
            wait_idle();
        end

        // Consumer stall: result held, no new request admitted.
        out_ready = 1'b0;
        issue(32'd1000, 32'd3, 1'b0, 1, 32'd333, 32'd1);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("handoff_out_valid", {31'b0, out_valid}, 32'd0);
        chk("handoff_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush mid-calculation with a competing request.
        issue(32'd500, 32'd5, 1'b0, 0, 32'd0, 32'd0);
        repeat (9) @(negedge clock);
        flush = 1'b1; in_valid = 1'b1; x = 32'd77; y = 32'd7;
        @(posedge clock);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (40) @(negedge clock);
        chk("flush_no_result", {31'b0, out_valid}, 32'd0);

        // Flush beats a request while idle.
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush beats out_ready=0 hold in DONE.
        out_ready = 1'b0;
        issue(32'd81, 32'd9, 1'b0, 1, 32'd9, 32'd0);
        wait_ov();
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        chk("flush_done_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_done_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Asynchronous reset mid-calculation.
        issue(32'd12345, 32'd11, 1'b0, 0, 32'd0, 32'd0);
        repeat (19) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_quotient", quotient, 32'd0);
        chk("rst_mid_remainder", remainder, 32'd0);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        #2 reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("rst_mid_no_result", {31'b0, out_valid}, 32'd0);
        issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        wait_idle();

        // Asynchronous reset while a result waits.
        out_ready = 1'b0;
        issue(32'd50, 32'd6, 1'b0, 1, 32'd8, 32'd2);
        wait_ov();
        #2 reset_n = 1'b0;
        #1 chk("rst_done_out_valid", {31'b0, out_valid}, 32'd0);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (40) @(negedge clock);
        chk("rst_done_no_result", {31'b0, out_valid}, 32'd0);

        // Random regression with a randomly stalling consumer.
        rdy_rand = 1;
        for (int i = 0; i < 1200; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er);
            issue(a, b, s, 1, eq, er);
        end
        wait_idle();
        rdy_rand = 0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
